// File: rtl/param_updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared constants and helpers for the parametrised up/down
//               counter. Provides direction/mode encodings and a constant
//               ceil(log2) used to size the prescaler counter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : param_updown_counter_if
// Description : Control/status bundle of the parametrised up/down counter.
//               master : drives data_in, load, enable, up_dn, sat_mode,
//                        clr_ovf; observes count, tc, wrap_pulse, ovf_sticky
//               slave  : the counter itself (inverse directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             enable;
    logic             up_dn;
    logic             sat_mode;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap_pulse;
    logic             ovf_sticky;

    modport master (
        output data_in, load, enable, up_dn, sat_mode, clr_ovf,
        input  count, tc, wrap_pulse, ovf_sticky
    );

    modport slave (
        input  data_in, load, enable, up_dn, sat_mode, clr_ovf,
        output count, tc, wrap_pulse, ovf_sticky
    );
endinterface
`default_nettype wire

// File: rtl/param_updown_counter_count_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : count_prescaler
// Description : Divides enabled cycles by PRESCALE and emits step_tick on the
//               last enabled cycle of each phase.
//   clk       in  : clock
//   reset     in  : asynchronous active-low reset
//   enable    in  : advances the phase counter (frozen while low)
//   sync_clr  in  : synchronous restart of the phase (counter load)
//   step_tick out : one count step is due this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module count_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic enable,
    input  wire logic sync_clr,
    output logic      step_tick
);
    localparam int PSC_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;

    // A load restarts the phase and suppresses the tick in the same cycle.
    assign step_tick = enable && !sync_clr && (psc_q == PSC_LAST);

    always_comb begin
        psc_d = psc_q;
        if (sync_clr) begin
            psc_d = '0;
        end else if (enable) begin
            psc_d = step_tick ? '0 : psc_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_updown_counter
// Description : Loadable up/down modulo counter with wrap or saturate mode,
//               prescaled clock-enable and boundary status.
//   clk    in  : clock
//   reset  in  : asynchronous active-low reset
//   bus    slave modport:
//            data_in/load  parallel load (clamped to MAX_COUNT)
//            enable        count enable, gated by the prescaler
//            up_dn/sat_mode direction and boundary behaviour
//            clr_ovf       clears ovf_sticky
//            count/tc/wrap_pulse/ovf_sticky  status outputs
// Revision    : 1.0 - initial release
// ============================================================================
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int PRESCALE  = 1,
    parameter int RESET_VAL = 0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    param_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             step_tick;
    logic             boundary_hit;

    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .enable    (bus.enable),
        .sync_clr  (bus.load),
        .step_tick (step_tick)
    );

    // Boundaries are tested by equality with MAX_COUNT / zero so that
    // non-power-of-two moduli wrap and no arithmetic overflows the width.
    always_comb begin
        count_d      = count_q;
        wrap_d       = 1'b0;
        ovf_d        = ovf_q;
        boundary_hit = 1'b0;

        if (bus.load) begin
            count_d = (bus.data_in > MAX_C) ? MAX_C : bus.data_in;
        end else if (step_tick) begin
            if (bus.up_dn == DIR_UP) begin
                if (count_q == MAX_C) begin
                    boundary_hit = 1'b1;
                    if (bus.sat_mode == MODE_WRAP) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    boundary_hit = 1'b1;
                    if (bus.sat_mode == MODE_WRAP) begin
                        count_d = MAX_C;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end

        // A boundary hit in the same cycle as clr_ovf keeps the flag set.
        if (boundary_hit) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RST_C;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.tc         = (bus.up_dn == DIR_UP) ? (count_q == MAX_C)
                                                  : (count_q == '0);
endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_updown_counter
// Description : Self-checking bench. Two counters share one stimulus stream:
//               d0 = defaults (mod 16, no prescale, reset 0),
//               d1 = MAX_COUNT 9, PRESCALE 3, RESET_VAL 5.
//               Each is compared every cycle against an integer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0, en = 1'b0, up = 1'b1, sat = 1'b0, clr = 1'b0;
    logic [3:0] din = 4'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(4)) bus0 ();
    param_updown_counter_if #(.WIDTH(4)) bus1 ();

    assign bus0.data_in = din;  assign bus1.data_in = din;
    assign bus0.load = load;    assign bus1.load = load;
    assign bus0.enable = en;    assign bus1.enable = en;
    assign bus0.up_dn = up;     assign bus1.up_dn = up;
    assign bus0.sat_mode = sat; assign bus1.sat_mode = sat;
    assign bus0.clr_ovf = clr;  assign bus1.clr_ovf = clr;

    param_updown_counter #(.WIDTH(4)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3), .RESET_VAL(5)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // ---------------- reference model ----------------
    int MAXC [2] = '{15, 9};
    int PSC  [2] = '{1, 3};
    int RV   [2] = '{0, 5};
    int m_cnt [2];
    int m_psc [2];
    bit m_wrap[2];
    bit m_ovf [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = RV[d]; m_psc[d] = 0; m_wrap[d] = 0; m_ovf[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit hit;
            bit wr;
            hit = 0; wr = 0;
            if (load) begin
                m_cnt[d] = (int'(din) > MAXC[d]) ? MAXC[d] : int'(din);
                m_psc[d] = 0;
            end else if (en) begin
                m_psc[d] = m_psc[d] + 1;
                if (m_psc[d] == PSC[d]) begin
                    m_psc[d] = 0;
                    if (up) begin
                        if (m_cnt[d] < MAXC[d]) m_cnt[d] = m_cnt[d] + 1;
                        else begin hit = 1; if (!sat) begin m_cnt[d] = 0; wr = 1; end end
                    end else begin
                        if (m_cnt[d] > 0) m_cnt[d] = m_cnt[d] - 1;
                        else begin hit = 1; if (!sat) begin m_cnt[d] = MAXC[d]; wr = 1; end end
                    end
                end
            end
            m_wrap[d] = wr;
            if (hit) m_ovf[d] = 1;
            else if (clr) m_ovf[d] = 0;
        end
    endtask

    // {count, tc, wrap_pulse, ovf_sticky}
    function automatic logic [6:0] expected(input int d);
        bit tcv;
        tcv = up ? (m_cnt[d] == MAXC[d]) : (m_cnt[d] == 0);
        return {4'(m_cnt[d]), tcv, m_wrap[d], m_ovf[d]};
    endfunction

    function automatic logic [6:0] observed(input int d);
        if (d == 0) return {bus0.count, bus0.tc, bus0.wrap_pulse, bus0.ovf_sticky};
        return {bus1.count, bus1.tc, bus1.wrap_pulse, bus1.ovf_sticky};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (observed(d) !== expected(d)) begin
                errors++;
                $display("FAIL reset d%0d got=%b exp=%b", d, observed(d), expected(d));
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_count_wrap();
        en = 1; up = 1; sat = 0; load = 0; clr = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observed(d) !== expected(d)) begin
                    errors++;
                    $display("FAIL count_wrap d%0d cyc%0d got=%b exp=%b", d, c, observed(d), expected(d));
                end
            end
        end
    endtask

    task automatic test_load();
        for (int c = 0; c < 8; c++) begin
            load = (c == 0); din = 4'd13; en = 1; up = 1; sat = 0;
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observed(d) !== expected(d)) begin
                    errors++;
                    $display("FAIL load d%0d cyc%0d got=%b exp=%b", d, c, observed(d), expected(d));
                end
            end
        end
        load = 0;
    endtask

    task automatic test_saturate();
        // load 14, saturate up, clr_ovf while still hitting, then clr idle
        for (int c = 0; c < 16; c++) begin
            load = (c == 0); din = 4'd14; up = 1; sat = 1;
            en  = (c < 12);
            clr = (c == 10) || (c == 13);
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observed(d) !== expected(d)) begin
                    errors++;
                    $display("FAIL saturate d%0d cyc%0d got=%b exp=%b", d, c, observed(d), expected(d));
                end
            end
        end
        clr = 0;
    endtask

    task automatic test_down_wrap();
        for (int c = 0; c < 14; c++) begin
            load = (c == 0); din = 4'd0; up = 0; sat = 0; en = 1; clr = 0;
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observed(d) !== expected(d)) begin
                    errors++;
                    $display("FAIL down_wrap d%0d cyc%0d got=%b exp=%b", d, c, observed(d), expected(d));
                end
            end
        end
        // saturate at zero going down
        for (int c = 0; c < 12; c++) begin
            load = (c == 0); din = 4'd1; up = 0; sat = 1; en = 1;
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observed(d) !== expected(d)) begin
                    errors++;
                    $display("FAIL down_sat d%0d cyc%0d got=%b exp=%b", d, c, observed(d), expected(d));
                end
            end
        end
        load = 0;
    endtask

    task automatic test_prescale_pause();
        // enable gaps mid-phase, direction flip mid-phase, load restart
        logic [19:0] en_pat;
        en_pat = 20'b1111_1100_1111_0011_1101;
        for (int c = 0; c < 20; c++) begin
            load = (c == 15); din = 4'd2; sat = 0; clr = 0;
            en = en_pat[c];
            up = (c < 9);
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observed(d) !== expected(d)) begin
                    errors++;
                    $display("FAIL prescale d%0d cyc%0d got=%b exp=%b", d, c, observed(d), expected(d));
                end
            end
        end
        load = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            load = ($urandom_range(0, 9) == 0);
            din  = 4'($urandom_range(0, 15));
            en   = ($urandom_range(0, 3) != 0);
            up   = ($urandom_range(0, 4) != 0) ^ (c >= 200);
            sat  = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 7) == 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observed(d) !== expected(d)) begin
                    errors++;
                    $display("FAIL random d%0d cyc%0d got=%b exp=%b", d, c, observed(d), expected(d));
                end
            end
        end
        load = 0; clr = 0;
    endtask

    task automatic test_async_reset();
        en = 1; up = 1; sat = 0;
        repeat (17) tick();
        #3;
        reset = 1'b0;          // between edges
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (observed(d) !== expected(d)) begin
                errors++;
                $display("FAIL async_reset d%0d got=%b exp=%b", d, observed(d), expected(d));
            end
        end
        @(posedge clk); #1;    // edges while held in reset change nothing
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (observed(d) !== expected(d)) begin
                errors++;
                $display("FAIL reset_hold d%0d got=%b exp=%b", d, observed(d), expected(d));
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observed(d) !== expected(d)) begin
                    errors++;
                    $display("FAIL post_reset d%0d cyc%0d got=%b exp=%b", d, c, observed(d), expected(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_load();
        test_saturate();
        test_down_wrap();
        test_prescale_pause();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
